// File: rtl/cache_axi_bridge_pkg.sv
// Shared types and AXI constants for the cache-to-AXI data bridge.
// Imported by the bridge, its strobe generator and the bus interface users.
package cache_axi_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WADDR,
    S_WRESP,
    S_DONE
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] LEN_SINGLE = 4'd0;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/cache_axi_bridge_if.sv
// Cache-side request bus plus the five AXI3 channels of the data port.
// master = bridge side, slave = cache + interconnect side.
interface cache_axi_bridge_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32
);

  logic                  cache_data_req;
  logic                  cache_data_wr;
  logic [1:0]            cache_data_size;
  logic [ADDR_WIDTH-1:0] cache_data_addr;
  logic [31:0]           cache_data_wdata;
  logic [31:0]           cache_data_rdata;
  logic                  cache_data_addr_ok;
  logic                  cache_data_data_ok;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [3:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [1:0]            arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [3:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic [1:0]            awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [ID_WIDTH-1:0]   wid;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    input  cache_data_req, cache_data_wr, cache_data_size,
    input  cache_data_addr, cache_data_wdata,
    output cache_data_rdata, cache_data_addr_ok, cache_data_data_ok,
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst,
    output awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output cache_data_req, cache_data_wr, cache_data_size,
    output cache_data_addr, cache_data_wdata,
    input  cache_data_rdata, cache_data_addr_ok, cache_data_data_ok,
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst,
    input  awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/cache_axi_bridge_wstrb_gen.sv
// Byte-lane strobe from access size and low address bits.
// Shared with the instruction-side bridge.
module axi_wstrb_gen
  import cache_axi_bridge_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] addr_i,
  output logic [3:0] wstrb_o
);

  always_comb begin
    wstrb_o = 4'b1111;
    unique case (1'b1)
      size_i == SIZE_BYTE: wstrb_o = 4'b0001 << addr_i;
      size_i == SIZE_HALF: wstrb_o = addr_i[1] ? 4'b1100 : 4'b0011;
      default:             wstrb_o = 4'b1111;
    endcase
  end

endmodule

// File: rtl/cache_axi_bridge.sv
// Single-outstanding bridge: cache req/addr_ok/data_ok to single-beat AXI3.
// One read refill, write-through or write-back word per request.
module cache_axi_bridge
  import cache_axi_bridge_pkg::*;
#(
  parameter int                  ID_WIDTH   = 4,
  parameter logic [ID_WIDTH-1:0] DATA_ID    = 'd1,
  parameter int                  ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  cache_axi_bridge_if.master     bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [3:0]            wstrb_new;
  logic                  unused_resp;

  axi_wstrb_gen u_wstrb (
    .size_i  (bus.cache_data_size),
    .addr_i  (bus.cache_data_addr[1:0]),
    .wstrb_o (wstrb_new)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cache_data_req) begin
          addr_d    = bus.cache_data_addr;
          size_d    = bus.cache_data_size;
          wdata_d   = bus.cache_data_wdata;
          wstrb_d   = wstrb_new;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = bus.cache_data_wr ? S_WADDR : S_RADDR;
        end
      end
      S_RADDR: if (bus.arready) state_d = S_RDATA;
      S_RDATA: begin
        if (bus.rvalid) begin
          rdata_d = bus.rdata;
          state_d = S_DONE;
        end
      end
      // AW and W complete independently; either order is legal
      S_WADDR: begin
        aw_done_d = aw_done_q | bus.awready;
        w_done_d  = w_done_q | bus.wready;
        if (aw_done_d && w_done_d) state_d = S_WRESP;
      end
      S_WRESP: if (bus.bvalid) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign bus.cache_data_addr_ok =
    resetn & (state_q == S_IDLE) & bus.cache_data_req;
  assign bus.cache_data_data_ok = (state_q == S_DONE);
  assign bus.cache_data_rdata   = rdata_q;

  assign bus.arid    = DATA_ID;
  assign bus.araddr  = addr_q;
  assign bus.arlen   = LEN_SINGLE;
  assign bus.arsize  = {1'b0, size_q};
  assign bus.arburst = BURST_INCR;
  assign bus.arlock  = '0;
  assign bus.arcache = '0;
  assign bus.arprot  = '0;
  assign bus.arvalid = (state_q == S_RADDR);
  assign bus.rready  = (state_q == S_RDATA);

  assign bus.awid    = DATA_ID;
  assign bus.awaddr  = addr_q;
  assign bus.awlen   = LEN_SINGLE;
  assign bus.awsize  = {1'b0, size_q};
  assign bus.awburst = BURST_INCR;
  assign bus.awlock  = '0;
  assign bus.awcache = '0;
  assign bus.awprot  = '0;
  assign bus.awvalid = (state_q == S_WADDR) & ~aw_done_q;

  assign bus.wid     = DATA_ID;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb_q;
  assign bus.wlast   = 1'b1;
  assign bus.wvalid  = (state_q == S_WADDR) & ~w_done_q;
  assign bus.bready  = (state_q == S_WRESP);

  // Responses and IDs are not checked by this bridge
  assign unused_resp =
    ^{bus.rid, bus.rresp, bus.rlast, bus.bid, bus.bresp};

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Randomised bench for cache_axi_bridge with a behavioural AXI slave.
// Expected values come from per-transaction rules, not RTL state.
module tb_cache_axi_bridge;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_err;

  cache_axi_bridge_if #(.ID_WIDTH(4), .ADDR_WIDTH(32)) bus ();

  cache_axi_bridge #(
    .ID_WIDTH   (4),
    .DATA_ID    (4'd1),
    .ADDR_WIDTH (32)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          timeout;
    int          lat;
    int          pulses;
    int          early_ack;
    bit          late_ack;
    logic [31:0] rdata;
    int          ar_hi;
    int          aw_hi;
    int          w_hi;
    bit          ar_unstable;
    bit          const_err;
    bit          order_err;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } obs_t;

  logic [31:0] last_rd;

  function automatic logic [3:0] exp_strb(logic [1:0] sz, logic [1:0] a);
    if (sz == 2'd0) return 4'b0001 << a;
    if (sz == 2'd1) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  task automatic idle_inputs();
    bus.cache_data_req   = 1'b0;
    bus.cache_data_wr    = 1'b0;
    bus.cache_data_size  = 2'd0;
    bus.cache_data_addr  = '0;
    bus.cache_data_wdata = '0;
    bus.arready = 1'b0;
    bus.rid     = 4'd1;
    bus.rdata   = '0;
    bus.rresp   = 2'b00;
    bus.rlast   = 1'b1;
    bus.rvalid  = 1'b0;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bid     = 4'd1;
    bus.bresp   = 2'b00;
    bus.bvalid  = 1'b0;
  endtask

  // Drives one cache request and plays the AXI slave with given wait states.
  task automatic run_txn(
    input logic wr, input logic [1:0] sz, input logic [31:0] a,
    input logic [31:0] wd, input int arw, input int rw, input int aww,
    input int ww, input int bw, input logic [1:0] br,
    input logic [31:0] rd, input bit hold, output obs_t o);
    int c, t0, td, arc, rc, awc, wc, bc;
    bit acc, drop;
    o = '{default: 0};
    c = 0; t0 = -1; td = -1;
    arc = 0; rc = 0; awc = 0; wc = 0; bc = 0;
    acc = 0;
    @(posedge clk); #1;
    bus.cache_data_req   = 1'b1;
    bus.cache_data_wr    = wr;
    bus.cache_data_size  = sz;
    bus.cache_data_addr  = a;
    bus.cache_data_wdata = wd;
    while (c < 80) begin
      @(negedge clk);
      drop = 0;
      if (bus.cache_data_addr_ok) begin
        if (!acc) begin
          t0 = c; acc = 1; drop = !hold;
        end else if (td < 0) begin
          o.early_ack++;
        end else begin
          o.late_ack = 1;
          bus.cache_data_req = 1'b0;
        end
      end
      if (bus.cache_data_data_ok) begin
        o.pulses++;
        if (td < 0) begin
          td = c;
          o.rdata = bus.cache_data_rdata;
        end
      end
      if (bus.arvalid) begin
        if (o.ar_hi == 0) begin
          o.araddr = bus.araddr;
          o.arsize = bus.arsize;
        end else if (bus.araddr !== o.araddr || bus.arsize !== o.arsize)
          o.ar_unstable = 1;
        if (bus.arlen !== 4'd0 || bus.arburst !== 2'b01 ||
            bus.arlock !== 2'd0 || bus.arcache !== 4'd0 ||
            bus.arprot !== 3'd0 || bus.arid !== 4'd1)
          o.const_err = 1;
        o.ar_hi++;
        arc++;
      end
      bus.arready = bus.arvalid && (arc > arw);
      if (bus.rready) rc++;
      bus.rvalid = bus.rready && (rc > rw);
      bus.rdata  = bus.rvalid ? rd : 32'h0;
      if (bus.awvalid) begin
        if (o.aw_hi == 0) begin
          o.awaddr = bus.awaddr;
          o.awsize = bus.awsize;
        end
        if (bus.awlen !== 4'd0 || bus.awburst !== 2'b01 ||
            bus.awlock !== 2'd0 || bus.awcache !== 4'd0 ||
            bus.awprot !== 3'd0 || bus.awid !== 4'd1)
          o.const_err = 1;
        o.aw_hi++;
        awc++;
      end
      bus.awready = bus.awvalid && (awc > aww);
      if (bus.wvalid) begin
        if (o.w_hi == 0) begin
          o.wstrb = bus.wstrb;
          o.wdata = bus.wdata;
        end
        if (bus.wlast !== 1'b1 || bus.wid !== 4'd1) o.const_err = 1;
        o.w_hi++;
        wc++;
      end
      bus.wready = bus.wvalid && (wc > ww);
      if (bus.bready) begin
        if (bus.awvalid || bus.wvalid) o.order_err = 1;
        bc++;
      end
      bus.bvalid = bus.bready && (bc > bw);
      bus.bresp  = br;
      c++;
      if (td >= 0 && c > td + 3) break;
      if (drop) begin
        @(posedge clk); #1;
        bus.cache_data_req = 1'b0;
      end
    end
    o.timeout = (td < 0);
    o.lat = td - t0 + 1;
    bus.cache_data_req = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    bus.cache_data_req = 1'b1;
    last_rd = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.cache_data_addr_ok !== 1'b0) begin
      n_err++;
      $display("FAIL reset_addr_ok: got %b want 0", bus.cache_data_addr_ok);
    end
    n_cmp++;
    if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready,
         bus.cache_data_data_ok} !== 6'b0 || bus.cache_data_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b/%h want 0/0",
               {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
                bus.bready, bus.cache_data_data_ok}, bus.cache_data_rdata);
    end
    bus.cache_data_req = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_word_read();
    obs_t o;
    run_txn(0, 2'd2, 32'h1FC0_0010, 32'h0, 0, 0, 0, 0, 0, 2'b00,
            32'hDEAD_BEEF, 0, o);
    last_rd = 32'hDEAD_BEEF;
    n_cmp++;
    if (o.timeout || o.lat != 4 || o.pulses != 1) begin
      n_err++;
      $display("FAIL word_read_timing: lat %0d pulses %0d to %b want 4/1/0",
               o.lat, o.pulses, o.timeout);
    end
    n_cmp++;
    if (o.araddr !== 32'h1FC0_0010 || o.arsize !== 3'd2 || o.const_err) begin
      n_err++;
      $display("FAIL word_read_ar: got %h/%0d/%b want 1fc00010/2/0",
               o.araddr, o.arsize, o.const_err);
    end
    n_cmp++;
    if (o.rdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL word_read_data: got %h want deadbeef", o.rdata);
    end
  endtask

  task automatic test_byte_write();
    obs_t o;
    run_txn(1, 2'd0, 32'h0000_0103, 32'hAA00_0000, 0, 0, 0, 0, 1, 2'b00,
            32'h0, 0, o);
    n_cmp++;
    if (o.wstrb !== 4'b1000 || o.awsize !== 3'd0 || o.const_err) begin
      n_err++;
      $display("FAIL byte_write_fields: got %b/%0d/%b want 1000/0/0",
               o.wstrb, o.awsize, o.const_err);
    end
    n_cmp++;
    if (o.awaddr !== 32'h103 || o.wdata !== 32'hAA00_0000) begin
      n_err++;
      $display("FAIL byte_write_addr: got %h/%h want 103/aa000000",
               o.awaddr, o.wdata);
    end
    n_cmp++;
    if (o.timeout || o.lat != 5 || o.pulses != 1) begin
      n_err++;
      $display("FAIL byte_write_timing: lat %0d pulses %0d want 5/1",
               o.lat, o.pulses);
    end
  endtask

  task automatic test_aw_w_order();
    obs_t o;
    run_txn(1, 2'd2, 32'h0000_2000, 32'h1234_5678, 0, 0, 3, 0, 0, 2'b00,
            32'h0, 0, o);
    n_cmp++;
    if (o.aw_hi != 4 || o.w_hi != 1 || o.order_err || o.lat != 7) begin
      n_err++;
      $display("FAIL aw_stall: aw %0d w %0d ord %b lat %0d want 4/1/0/7",
               o.aw_hi, o.w_hi, o.order_err, o.lat);
    end
    run_txn(1, 2'd2, 32'h0000_2004, 32'h8765_4321, 0, 0, 0, 3, 0, 2'b00,
            32'h0, 0, o);
    n_cmp++;
    if (o.aw_hi != 1 || o.w_hi != 4 || o.order_err || o.lat != 7) begin
      n_err++;
      $display("FAIL w_stall: aw %0d w %0d ord %b lat %0d want 1/4/0/7",
               o.aw_hi, o.w_hi, o.order_err, o.lat);
    end
  endtask

  task automatic test_back_pressure();
    obs_t o;
    run_txn(0, 2'd2, 32'h0000_4440, 32'h0, 5, 0, 0, 0, 0, 2'b00,
            32'hCAFE_F00D, 1, o);
    last_rd = 32'hCAFE_F00D;
    n_cmp++;
    if (o.ar_hi != 6 || o.ar_unstable || o.araddr !== 32'h4440) begin
      n_err++;
      $display("FAIL ar_stall: hi %0d unstable %b addr %h want 6/0/4440",
               o.ar_hi, o.ar_unstable, o.araddr);
    end
    n_cmp++;
    if (o.early_ack != 0 || !o.late_ack || o.lat != 9) begin
      n_err++;
      $display("FAIL held_req: early %0d late %b lat %0d want 0/1/9",
               o.early_ack, o.late_ack, o.lat);
    end
  endtask

  task automatic test_mid_reset();
    obs_t o;
    bit seen;
    seen = 0;
    @(posedge clk); #1;
    bus.cache_data_req  = 1'b1;
    bus.cache_data_wr   = 1'b0;
    bus.cache_data_size = 2'd2;
    bus.cache_data_addr = 32'h0000_0800;
    bus.arready = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.arvalid) bus.cache_data_req = 1'b0;
      if (bus.rready) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL mid_reset_reach: got no rready want rready");
    end
    resetn = 1'b0;
    bus.cache_data_req = 1'b0;
    bus.arready = 1'b0;
    #1;
    n_cmp++;
    if ({bus.rready, bus.arvalid, bus.cache_data_data_ok} !== 3'b0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got %b want 000",
               {bus.rready, bus.arvalid, bus.cache_data_data_ok});
    end
    last_rd = 32'h0;
    n_cmp++;
    if (bus.cache_data_rdata !== last_rd) begin
      n_err++;
      $display("FAIL mid_reset_rdata: got %h want 0", bus.cache_data_rdata);
    end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    run_txn(0, 2'd2, 32'h0000_0804, 32'h0, 0, 0, 0, 0, 0, 2'b00,
            32'h5A5A_0F0F, 0, o);
    last_rd = 32'h5A5A_0F0F;
    n_cmp++;
    if (o.timeout || o.lat != 4 || o.rdata !== 32'h5A5A_0F0F) begin
      n_err++;
      $display("FAIL post_reset_read: lat %0d data %h want 4/5a5a0f0f",
               o.lat, o.rdata);
    end
  endtask

  task automatic test_half_write_slverr();
    obs_t o;
    run_txn(1, 2'd1, 32'h0000_0106, 32'hBEEF_0000, 0, 0, 0, 0, 0, 2'b10,
            32'h0, 0, o);
    n_cmp++;
    if (o.wstrb !== 4'b1100 || o.awsize !== 3'd1) begin
      n_err++;
      $display("FAIL half_write_strb: got %b/%0d want 1100/1",
               o.wstrb, o.awsize);
    end
    n_cmp++;
    if (o.timeout || o.pulses != 1 || o.lat != 4) begin
      n_err++;
      $display("FAIL slverr_done: pulses %0d lat %0d want 1/4",
               o.pulses, o.lat);
    end
    n_cmp++;
    if (o.rdata !== last_rd) begin
      n_err++;
      $display("FAIL rdata_hold: got %h want %h", o.rdata, last_rd);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] a, wd, rd;
    int          arw, rw, aww, ww, bw, exp_lat;
    for (int n = 0; n < 40; n++) begin
      wr  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      a   = $urandom;
      wd  = $urandom;
      rd  = $urandom;
      arw = $urandom_range(0, 3);
      rw  = $urandom_range(0, 3);
      aww = $urandom_range(0, 3);
      ww  = $urandom_range(0, 3);
      bw  = $urandom_range(0, 3);
      run_txn(wr, sz, a, wd, arw, rw, aww, ww, bw,
              2'($urandom_range(0, 3)), rd, 0, o);
      exp_lat = wr ? 4 + ((aww > ww) ? aww : ww) + bw : 4 + arw + rw;
      n_cmp++;
      if (o.timeout || o.lat != exp_lat || o.pulses != 1 ||
          o.early_ack != 0 || o.const_err || o.order_err) begin
        n_err++;
        $display("FAIL rnd%0d_ctl: lat %0d/%0d pulses %0d ack %0d c %b o %b",
                 n, o.lat, exp_lat, o.pulses, o.early_ack,
                 o.const_err, o.order_err);
      end
      if (wr) begin
        n_cmp++;
        if (o.awaddr !== a || o.awsize !== {1'b0, sz} ||
            o.wstrb !== exp_strb(sz, a[1:0]) || o.wdata !== wd ||
            o.rdata !== last_rd) begin
          n_err++;
          $display("FAIL rnd%0d_wr: %h/%0d/%b/%h/%h want %h/%0d/%b/%h/%h",
                   n, o.awaddr, o.awsize, o.wstrb, o.wdata, o.rdata,
                   a, sz, exp_strb(sz, a[1:0]), wd, last_rd);
        end
      end else begin
        n_cmp++;
        if (o.araddr !== a || o.arsize !== {1'b0, sz} || o.rdata !== rd) begin
          n_err++;
          $display("FAIL rnd%0d_rd: %h/%0d/%h want %h/%0d/%h",
                   n, o.araddr, o.arsize, o.rdata, a, sz, rd);
        end
        last_rd = rd;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_word_read();
    test_byte_write();
    test_aw_w_order();
    test_back_pressure();
    test_mid_reset();
    test_half_write_slverr();
    test_random();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_axi_bridge.md
Name: cache_axi_bridge

Overview:
- Single-outstanding bridge that sits directly downstream of the LRU data cache.
- Converts the cache's request/addr_ok/data_ok memory interface (cache_data_*) into single-beat AXI3 master transactions on the SoC data port.
- Carries one transaction type per request: a read-miss refill, a write-through word, or a dirty write-back word.
- Every transaction is a single 32-bit beat, so no bursts are generated.

Parameters:
- ID_WIDTH, 4, width of arid/awid/wid/rid/bid.
- DATA_ID, 1, constant ID driven on arid, awid and wid.
- ADDR_WIDTH, 32, AXI address width; the cache address passes through unchanged.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- cache_data_req  in  1  request valid from cache.
- cache_data_wr  in  1  1 = write, 0 = read.
- cache_data_size  in  2  0 = byte, 1 = half, 2 = word.
- cache_data_addr  in  32  byte address.
- cache_data_wdata  in  32  write data.
- cache_data_rdata  out  32  read data, valid when data_ok is high.
- cache_data_addr_ok  out  1  request accepted.
- cache_data_data_ok  out  1  transaction complete, 1-cycle pulse.
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  ID_WIDTH/32/4/3/2/2/4/3/1  AXI AR channel.
- arready  in  1.
- rid/rdata/rresp/rlast/rvalid  in  ID_WIDTH/32/2/1/1  AXI R channel.
- rready  out  1.
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  same widths as AR  AXI AW channel.
- awready  in  1.
- wid/wdata/wstrb/wlast/wvalid  out  ID_WIDTH/32/4/1/1  AXI W channel.
- wready  in  1.
- bid/bresp/bvalid  in  ID_WIDTH/2/1  AXI B channel.
- bready  out  1.

Behaviour:
- Reset (resetn low, takes effect immediately):
  - state = IDLE; all valid and ready outputs 0; data_ok 0; rdata 0; address, data and strobe registers 0.
  - An AXI transaction in flight at reset is abandoned; the interconnect is reset together with the bridge.
- States: IDLE, RADDR, RDATA, WADDR, WRESP, DONE.
- IDLE:
  - addr_ok = cache_data_req (combinational; 0 while in reset).
  - On req, latch wr, size, addr and wdata, and compute wstrb.
  - Next state is WADDR if wr=1, otherwise RADDR.
- RADDR:
  - arvalid=1 with araddr = latched address and arsize = {0,size}.
  - On arready, go to RDATA.
  - araddr and arsize stay stable until the handshake.
- RDATA:
  - rready=1.
  - On rvalid, capture rdata into cache_data_rdata and go to DONE.
  - rresp is ignored and rid is not checked.
- WADDR:
  - awvalid and wvalid are raised together, with two sticky done flags, one per channel.
  - Each valid drops in the cycle after its own handshake.
  - When both flags are set, including the case where both handshake in the same cycle, go to WRESP.
  - W may handshake before AW; this is legal.
- WRESP:
  - bready=1.
  - On bvalid, go to DONE; bresp is ignored.
- DONE:
  - data_ok=1 for exactly one cycle, then return to IDLE.
  - rdata holds its value until the next read capture.
- Latency: from the cycle addr_ok is high to the data_ok pulse, minimum 4 cycles for a read and 4 cycles for a write, when the slave responds with zero wait states.
- Constant fields:
  - arlen = awlen = 0, arburst = awburst = 01 (INCR), wlast = 1.
  - lock, cache and prot = 0.
  - wid = awid = arid = DATA_ID.
- wstrb:
  - size 0: one-hot of addr[1:0].
  - size 1: 1100 if addr[1] else 0011.
  - size 2 or 3: 1111.
- wdata: passed unshifted; the cache already places bytes in their lanes.
- Back-pressure:
  - addr_ok is 0 in every state other than IDLE; the cache keeps req asserted until it sees addr_ok.
  - A new req in the DONE cycle is not accepted until the following IDLE cycle.
- At most one AXI transaction is outstanding at any time.

Decomposition:
- Shared package:
  - state enum;
  - AXI constants: BURST_INCR = 2'b01, LEN_SINGLE = 0, RESP_OKAY = 2'b00;
  - size encodings: SIZE_BYTE, SIZE_HALF, SIZE_WORD.
- One natural sub-module, axi_wstrb_gen: combinational size + addr[1:0] -> wstrb, reusable by the instruction-side bridge.

Test Plan:
- Word read: req, wr=0, addr 0x1FC0_0010, size 2.
  - Required: addr_ok in the same cycle; araddr 0x1FC0_0010, arsize 2, arlen 0.
  - Slave returns 0xDEAD_BEEF -> data_ok pulses once with rdata 0xDEAD_BEEF; total 4 cycles with a zero-wait slave.
- Byte write: addr 0x0000_0103, size 0, wdata 0xAA00_0000.
  - Required: wstrb 1000, awsize 0, wlast 1; data_ok pulses after bvalid.
- AW/W ordering:
  - awready stalled 3 cycles while wready is immediate -> wvalid drops after 1 cycle, awvalid held, WRESP entered only after AW completes.
  - Repeat with AW immediate and W stalled -> symmetric behaviour.
- Back-pressure: arready low for 5 cycles.
  - Required: arvalid and araddr stable throughout; a second req held by the cache gets no addr_ok until after the first data_ok.
- Reset mid-operation: assert resetn=0 during RDATA.
  - Required: rready, arvalid and data_ok go to 0 immediately; after release the bridge is in IDLE and a new read completes normally.
- Half write: addr 0x..06, size 1 -> wstrb 1100.
  - bresp = SLVERR -> data_ok is still a single pulse and the bridge returns to IDLE.
